snd_lpf_mixer: RTL and testbench
================================

Name: snd_lpf_mixer

Overview:
- Parametrised successor to the per-board AY channel filter and mix stage.
- Takes CHANNELS signed, DC-removed PSG channel samples and applies a per-channel selectable one-pole low-pass filter (bypass plus NFILT programmable cutoffs).
- Sums the selected results into one signed mono output, with optional phase inversion and saturation.
- Uses one time-multiplexed MAC instead of one filter instance per channel per cutoff; sits between the PSG DC-removal stage and the core audio output.

Parameters:
- CHANNELS, 6, number of input channels (1..16).
- W, 16, sample width in and out (signed).
- NFILT, 3, number of programmable filters per channel (1..3); select 0 = bypass.
- COEF_W, 16, unsigned alpha width; alpha = 2^COEF_W * (1 - e^(-2*pi*fc/fs)).
- DEF_ALPHA, {16'd2769,16'd3242,16'd14049}, reset alpha per filter index 3..1 (packed, filter 1 in LSBs).
- INVERT, 1, 1 = output is -1 - sum (inverting op-amp model); 0 = output is sum.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cen_sample  in  1  one-cycle strobe starting a sample frame.
- in_flat  in  CHANNELS*W  signed samples, channel 0 in LSBs.
- sel_we  in  1  write filter selects.
- sel_flat  in  CHANNELS*2  per-channel select (0 bypass, 1..NFILT filter).
- coef_we  in  1  write one alpha.
- coef_idx  in  2  filter index 1..NFILT.
- coef_data  in  COEF_W  alpha value.
- out  out  W  signed mixed sample.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; a cen_sample arrived while busy.

Behaviour:
- Reset, all synchronous: out=0, out_valid=0, busy=0, overrun=0; all filter states=0; active and shadow selects=0; alphas=DEF_ALPHA.
- Filter state is held per channel per filter (CHANNELS*NFILT registers). Every filter runs every frame regardless of select, so switching selects is glitch-free.
- FSM states are IDLE, RUN, MIX, DONE.
  - IDLE: on cen_sample, snapshot in_flat, copy shadow selects to active, clear accumulator, slot=0, go to RUN.
  - RUN: one slot per clock, slot = ch*NFILT + f. Compute y' = y + (((x - y) * alpha_f) >>> COEF_W), with x - y taken at W+1 bits and the product at W+1+COEF_W+1 bits, arithmetic shift. Clamp y' to the W range and write it back. If active_sel[ch] == f+1, add y' to the accumulator. On the last filter slot of a channel with active_sel[ch] == 0, add raw x instead. After slot CHANNELS*NFILT-1, go to MIX.
  - MIX: accumulator width is W+ceil(log2(CHANNELS))+1. Result = INVERT ? (-1 - acc) : acc. Saturate to [-2^(W-1), 2^(W-1)-1] and register to out. Go to DONE.
  - DONE: out_valid=1 for one cycle, then IDLE.
- Latency: cen_sample to out_valid is CHANNELS*NFILT + 2 cycles (20 at defaults).
- busy is high in RUN, MIX and DONE.
- cen_sample while busy is ignored and sets overrun. overrun clears only on reset.
- sel_we may arrive at any time and writes only the shadow register. The new selects take effect at the next frame start, never mid-frame. If sel_we and cen_sample coincide in IDLE, the new value is used for that frame.
- Select values greater than NFILT are treated as bypass.
- coef_we writes take effect immediately, including mid-frame; the new alpha applies to slots not yet processed. coef_idx of 0 or greater than NFILT is ignored.
- Reset during RUN aborts the frame, clears all state, and produces no out_valid.

Optional Feature:
- Macro SND_LPF_MIXER_PEAK_EN.
- When defined, adds output port peak (W-1 bits, unsigned): the running maximum of |out| (with |-2^(W-1)| saturated to 2^(W-1)-1), updated on out_valid. Adds input peak_clr (1 bit), which zeroes peak in the same cycle, with priority over an update.
- When undefined, neither port exists and no meter logic is built.

Decomposition:
- Package snd_lpf_mixer_pkg holds:
  - the FSM state enum (IDLE, RUN, MIX, DONE);
  - localparam SEL_BYPASS=0;
  - function sat_w(value, width) for the symmetric saturating clamp.
- Sub-module snd_lpf_mac: the combinational-plus-register one-pole update (x, y, alpha -> y'), shared by all slots.

Test Plan:
- Reset, then cen_sample with all inputs 100 and selects 0 -> out_valid after 20 cycles, out = -1-600 = -601.
- Channel 0 = +16384, others 0, select 1 on ch0, alpha=14049 -> frame 1 y = 16384*14049>>16 = 3512 (floor), out = -3513; later frames approach out = -16385 monotonically.
- All channels = +32767, bypass, INVERT=1 -> acc 196602, out saturates to -32768. With INVERT=0, out = +32767.
- sel_we writes ch2=2 during RUN -> current frame still uses the old select; the next frame uses filter 2.
- cen_sample pulsed 5 cycles into a frame -> ignored, overrun=1, frame completes at cycle 20 unaffected.
- reset asserted at cycle 10 of RUN -> no out_valid, out=0, busy=0; the next cen_sample starts from zeroed filter states.

Source files
------------

// File: rtl/snd_lpf_mixer_pkg.sv
// Shared definitions for the AY channel filter and mix stage: the frame
// sequencer states, the bypass select code and the saturating clamp used by
// both the per-slot filter update and the final mix.
package snd_lpf_mixer_pkg;

  // Frame sequencer: wait for a strobe, walk every filter slot, mix, publish
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Select code meaning "pass the raw channel sample through"
  localparam logic [1:0] SEL_BYPASS = 2'd0;

  // Clamp a signed value to the two's complement range of a width-bit word.
  // Callers size-cast the result down to their own width.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                               input int width);
    logic signed [63:0] hiLimit;
    logic signed [63:0] loLimit;
    hiLimit = (64'sd1 <<< (width - 1)) - 64'sd1;
    loLimit = -hiLimit - 64'sd1;
    if (value > hiLimit) begin
      return hiLimit;
    end else if (value < loLimit) begin
      return loLimit;
    end
    return value;
  endfunction

endpackage

// File: rtl/snd_lpf_mac.sv
// Shared one-pole low-pass update for every (channel, filter) slot.
// Holds the filter state of all slots and computes, for the addressed slot,
//   y' = y + (((x - y) * alpha) >>> COEF_W)
// clamped to the sample range. y' is offered combinationally so the mixer
// can accumulate it in the same cycle it is written back.
module snd_lpf_mac
  import snd_lpf_mixer_pkg::*;
#(
  parameter int W      = 16,
  parameter int COEF_W = 16,
  parameter int NSLOT  = 18,
  parameter int SLOT_W = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [SLOT_W-1:0]        slot_i,
  input  logic signed [W-1:0]      x_i,
  input  logic [COEF_W-1:0]        alpha_i,
  output logic signed [W-1:0]      y_o
);

  localparam int PW = W + COEF_W + 2;

  logic signed [W-1:0]  state_q [NSLOT];
  logic signed [W-1:0]  yCur;
  logic signed [W:0]    diff;
  logic signed [PW-1:0] prod;
  logic signed [W+1:0]  step;
  logic signed [W+1:0]  ySum;

  // Filter update datapath: difference at W+1 bits, full-width product,
  // arithmetic shift (floor), then add back and clamp
  always_comb begin
    yCur = state_q[slot_i];
    diff = {x_i[W-1], x_i} - {yCur[W-1], yCur};
    prod = $signed({{(COEF_W + 1){diff[W]}}, diff}) *
           $signed({{(W + 2){1'b0}}, alpha_i});
    step = (W + 2)'(prod >>> COEF_W);
    ySum = $signed({{2{yCur[W-1]}}, yCur}) + step;
    y_o  = W'(sat_w(64'(ySum), W));
  end

  // Filter state storage; the addressed slot takes its new value when enabled
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= '0;
      end
    end else if (en_i) begin
      state_q[slot_i] <= y_o;
    end
  end

endmodule

// File: rtl/snd_lpf_mixer.sv
// AY channel filter and mix stage, parametrised.
// Each sample frame walks all CHANNELS*NFILT filter slots through one shared
// update unit, accumulates the selected output of every channel (or its raw
// sample when bypassed), then inverts/saturates into a mono sample.
// Optional build macro SND_LPF_MIXER_PEAK_EN adds a |out| peak meter
// (ports peak, peak_clr).
module snd_lpf_mixer
  import snd_lpf_mixer_pkg::*;
#(
  parameter int                       CHANNELS  = 6,
  parameter int                       W         = 16,
  parameter int                       NFILT     = 3,
  parameter int                       COEF_W    = 16,
  parameter logic [NFILT*COEF_W-1:0]  DEF_ALPHA = {16'd2769, 16'd3242, 16'd14049},
  parameter int                       INVERT    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cen_sample,
  input  logic [CHANNELS*W-1:0]      in_flat,
  input  logic                       sel_we,
  input  logic [CHANNELS*2-1:0]      sel_flat,
  input  logic                       coef_we,
  input  logic [1:0]                 coef_idx,
  input  logic [COEF_W-1:0]          coef_data,
`ifdef SND_LPF_MIXER_PEAK_EN
  input  logic                       peak_clr,
  output logic [W-2:0]               peak,
`endif
  output logic signed [W-1:0]        out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int NSLOT  = CHANNELS * NFILT;
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W  = W + $clog2(CHANNELS) + 1;
  localparam logic [1:0]        NFILT_L   = 2'(NFILT);
  localparam logic [1:0]        LAST_F    = 2'(NFILT - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  state_e                    state_q, state_d;
  logic signed [W-1:0]       sample_q    [CHANNELS];
  logic [1:0]                shadowSel_q [CHANNELS];
  logic [1:0]                activeSel_q [CHANNELS];
  logic [COEF_W-1:0]         alpha_q     [NFILT];
  logic [SLOT_W-1:0]         slot_q;
  logic [CH_W-1:0]           chIdx_q;
  logic [1:0]                fIdx_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]       out_q;
  logic                      outValid_q;
  logic                      overrun_q;

  logic                      macEn;
  logic signed [W-1:0]       xCur;
  logic [COEF_W-1:0]         alphaCur;
  logic signed [W-1:0]       yNew;
  logic [1:0]                selCur;
  logic                      selBypass;
  logic                      lastFilter;
  logic                      lastSlot;
  logic signed [ACC_W-1:0]   mixVal;
  logic                      frameStart;

  assign frameStart = (state_q == IDLE) && cen_sample;
  assign xCur       = sample_q[chIdx_q];
  assign alphaCur   = alpha_q[fIdx_q];
  assign selCur     = activeSel_q[chIdx_q];
  assign selBypass  = (selCur == SEL_BYPASS) || (selCur > NFILT_L);
  assign lastFilter = (fIdx_q == LAST_F);
  assign lastSlot   = (slot_q == LAST_SLOT);
  assign mixVal     = (INVERT != 0) ? ~acc_q : acc_q;

  snd_lpf_mac #(
    .W      (W),
    .COEF_W (COEF_W),
    .NSLOT  (NSLOT),
    .SLOT_W (SLOT_W)
  ) u_mac (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (macEn),
    .slot_i  (slot_q),
    .x_i     (xCur),
    .alpha_i (alphaCur),
    .y_o     (yNew)
  );

  // Next-state and accumulator update: filter output joins the mix when it is
  // the channel's selected filter, raw sample joins on a bypassed channel's
  // last slot
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    macEn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cen_sample) begin
          state_d = RUN;
          acc_d   = '0;
        end
      end
      RUN: begin
        macEn = 1'b1;
        if (selCur == (fIdx_q + 2'd1)) begin
          acc_d = acc_q + ACC_W'(yNew);
        end else if (lastFilter && selBypass) begin
          acc_d = acc_q + ACC_W'(xCur);
        end
        if (lastSlot) begin
          state_d = MIX;
        end
      end
      MIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and slot walk (channel-major, filter-minor)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      chIdx_q <= '0;
      fIdx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (frameStart) begin
        slot_q  <= '0;
        chIdx_q <= '0;
        fIdx_q  <= '0;
      end else if (state_q == RUN) begin
        slot_q <= slot_q + 1'b1;
        if (lastFilter) begin
          fIdx_q  <= '0;
          chIdx_q <= chIdx_q + 1'b1;
        end else begin
          fIdx_q <= fIdx_q + 2'd1;
        end
      end
    end
  end

  // Input snapshot and select double-buffering; a select written in the same
  // cycle as the frame strobe is used for that frame
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sample_q[i]    <= '0;
        shadowSel_q[i] <= SEL_BYPASS;
        activeSel_q[i] <= SEL_BYPASS;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel_we) begin
          shadowSel_q[i] <= sel_flat[i*2 +: 2];
        end
        if (frameStart) begin
          sample_q[i]    <= in_flat[i*W +: W];
          activeSel_q[i] <= sel_we ? sel_flat[i*2 +: 2] : shadowSel_q[i];
        end
      end
    end
  end

  // Cutoff coefficients; writes land immediately so later slots of a running
  // frame already see them, out-of-range indices are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NFILT; i++) begin
        alpha_q[i] <= DEF_ALPHA[i*COEF_W +: COEF_W];
      end
    end else if (coef_we && (coef_idx != 2'd0) && (coef_idx <= NFILT_L)) begin
      alpha_q[coef_idx - 2'd1] <= coef_data;
    end
  end

  // Accumulator, saturated output register, valid pulse and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      outValid_q <= (state_q == DONE);
      if (state_q == MIX) begin
        out_q <= W'(sat_w(64'(mixVal), W));
      end
      if (cen_sample && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef SND_LPF_MIXER_PEAK_EN
  logic [W-2:0] absOut;
  logic [W-2:0] peak_q;

  // Magnitude of the current output with the most negative code pinned to
  // full scale so it fits the unsigned meter width
  always_comb begin
    absOut = '0;
    if (out_q == {1'b1, {(W - 1){1'b0}}}) begin
      absOut = '1;
    end else if (out_q[W-1]) begin
      absOut = (W - 1)'(-out_q);
    end else begin
      absOut = (W - 1)'(out_q);
    end
  end

  // Running maximum, refreshed as each new sample is published; clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= '0;
    end else if ((state_q == DONE) && (absOut > peak_q)) begin
      peak_q <= absOut;
    end
  end

  assign peak = peak_q;
`endif

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_snd_lpf_mixer.sv
// Directed bench for snd_lpf_mixer: two instances at default parameters,
// one inverting and one non-inverting, driven by identical stimulus.
module tb_snd_lpf_mixer;

  localparam int CHANNELS = 6;
  localparam int W        = 16;
  localparam int COEF_W   = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       cen_sample;
  logic [CHANNELS*W-1:0]      in_flat;
  logic                       sel_we;
  logic [CHANNELS*2-1:0]      sel_flat;
  logic                       coef_we;
  logic [1:0]                 coef_idx;
  logic [COEF_W-1:0]          coef_data;
  logic signed [W-1:0]        out, outNoInv;
  logic                       out_valid, outValidNoInv;
  logic                       busy, busyNoInv;
  logic                       overrun, overrunNoInv;
`ifdef SND_LPF_MIXER_PEAK_EN
  logic                       peak_clr;
  logic [W-2:0]               peak, peakNoInv;
`endif

  int checks = 0;
  int passes = 0;

  int                 lat;
  logic               seen;
  logic               busyStart;
  logic signed [W-1:0] prevOut;

  snd_lpf_mixer dut (
    .clk        (clk),
    .reset      (reset),
    .cen_sample (cen_sample),
    .in_flat    (in_flat),
    .sel_we     (sel_we),
    .sel_flat   (sel_flat),
    .coef_we    (coef_we),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
`ifdef SND_LPF_MIXER_PEAK_EN
    .peak_clr   (peak_clr),
    .peak       (peak),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  snd_lpf_mixer #(.INVERT(0)) dutNoInv (
    .clk        (clk),
    .reset      (reset),
    .cen_sample (cen_sample),
    .in_flat    (in_flat),
    .sel_we     (sel_we),
    .sel_flat   (sel_flat),
    .coef_we    (coef_we),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
`ifdef SND_LPF_MIXER_PEAK_EN
    .peak_clr   (peak_clr),
    .peak       (peakNoInv),
`endif
    .out        (outNoInv),
    .out_valid  (outValidNoInv),
    .busy       (busyNoInv),
    .overrun    (overrunNoInv)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Count a comparison and report it when it does not hold
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end else begin
      passes++;
    end
  endtask

  function automatic logic [CHANNELS*W-1:0] allSamples(input logic [W-1:0] v);
    logic [CHANNELS*W-1:0] r;
    for (int i = 0; i < CHANNELS; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [CHANNELS*W-1:0] oneSample(input int ch, input logic [W-1:0] v);
    logic [CHANNELS*W-1:0] r;
    r = '0;
    r[ch*W +: W] = v;
    return r;
  endfunction

  function automatic logic [CHANNELS*2-1:0] selFor(input int ch, input logic [1:0] s);
    logic [CHANNELS*2-1:0] r;
    r = '0;
    r[ch*2 +: 2] = s;
    return r;
  endfunction

  task automatic doReset();
    reset      = 1'b1;
    cen_sample = 1'b0;
    sel_we     = 1'b0;
    coef_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Present channel samples and write the select shadow register
  task automatic applyStimulus(input logic [CHANNELS*W-1:0] samples,
                               input logic [CHANNELS*2-1:0] sels);
    in_flat  = samples;
    sel_flat = sels;
    sel_we   = 1'b1;
    @(posedge clk);
    #1;
    sel_we = 1'b0;
  endtask

  // Start a frame and wait (bounded) for out_valid, counting edges from the
  // strobe edge. Optionally inject a strobe (1), a select write (2) or a
  // reset (3) after edge injectAt.
  task automatic runFrame(input int injectAt, input int injectKind,
                          input logic [CHANNELS*2-1:0] injSel,
                          output int latency, output logic seenValid,
                          output logic busyAtStart);
    cen_sample = 1'b1;
    @(posedge clk);
    #1;
    cen_sample  = 1'b0;
    busyAtStart = busy;
    latency     = 0;
    seenValid   = 1'b0;
    while (!seenValid && latency < 60) begin
      @(posedge clk);
      #1;
      latency++;
      cen_sample = 1'b0;
      sel_we     = 1'b0;
      reset      = 1'b0;
      if (out_valid) begin
        seenValid = 1'b1;
      end else if (latency == injectAt) begin
        case (injectKind)
          1: cen_sample = 1'b1;
          2: begin sel_flat = injSel; sel_we = 1'b1; end
          3: reset = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cen_sample = 1'b0;
    sel_we     = 1'b0;
    coef_we    = 1'b0;
    in_flat    = '0;
    sel_flat   = '0;
    coef_idx   = 2'd0;
    coef_data  = '0;
`ifdef SND_LPF_MIXER_PEAK_EN
    peak_clr   = 1'b0;
`endif
    doReset();

    checkOutput("reset out", out, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset overrun", overrun, 0);

    // All channels 100, bypass: sum 600, inverted -601
    applyStimulus(allSamples(16'd100), '0);
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("busy in frame", busyStart, 1);
    checkOutput("latency", lat, 20);
    checkOutput("bypass sum inv", out, -601);
    checkOutput("bypass sum noinv", outNoInv, 600);
    checkOutput("no overrun", overrun, 0);
    @(posedge clk);
    #1;
    checkOutput("valid one cycle", out_valid, 0);
    checkOutput("idle after frame", busy, 0);

    // Step into filter 1 (alpha 14049) on channel 0
    doReset();
    applyStimulus(oneSample(0, 16'sd16384), selFor(0, 2'd1));
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("lpf frame1", out, -3513);
    checkOutput("lpf frame1 noinv", outNoInv, 3512);
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("lpf frame2", out, -6272);
    prevOut = out;
    for (int k = 0; k < 10; k++) begin
      runFrame(0, 0, '0, lat, seen, busyStart);
      checkOutput("lpf monotonic", (out < prevOut), 1);
      prevOut = out;
    end
    repeat (40) runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("lpf settles", (out <= -16381) && (out >= -16385), 1);

    // Full-scale bypass on every channel saturates
    doReset();
    applyStimulus(allSamples(16'sd32767), '0);
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("sat inv", out, -32768);
    checkOutput("sat noinv", outNoInv, 32767);

    // Select written mid-frame only applies from the next frame
    doReset();
    applyStimulus(oneSample(2, 16'sd16384), '0);
    runFrame(5, 2, selFor(2, 2'd2), lat, seen, busyStart);
    checkOutput("sel midframe old", out, -16385);
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("sel next frame f2", out, -1581);

    // Strobe during a frame is ignored and flagged
    doReset();
    applyStimulus(allSamples(16'd100), '0);
    runFrame(5, 1, '0, lat, seen, busyStart);
    checkOutput("overrun latency", lat, 20);
    checkOutput("overrun out", out, -601);
    checkOutput("overrun set", overrun, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("overrun sticky", overrun, 1);
    checkOutput("overrun no extra frame", busy, 0);
    doReset();
    checkOutput("overrun cleared", overrun, 0);

    // Reset in the middle of a frame aborts it and clears filter state
    applyStimulus(oneSample(0, 16'sd16384), selFor(0, 2'd1));
    runFrame(10, 3, '0, lat, seen, busyStart);
    checkOutput("abort no valid", seen, 0);
    checkOutput("abort out", out, 0);
    checkOutput("abort busy", busy, 0);
    applyStimulus(oneSample(0, 16'sd16384), selFor(0, 2'd1));
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("abort fresh state", out, -3513);

    // Coefficient rewrite for filter 1; index 0 write is dropped
    doReset();
    coef_idx  = 2'd1;
    coef_data = 16'd32768;
    coef_we   = 1'b1;
    @(posedge clk);
    #1;
    coef_idx  = 2'd0;
    coef_data = 16'd0;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    applyStimulus(oneSample(0, 16'sd16384), selFor(0, 2'd1));
    runFrame(0, 0, '0, lat, seen, busyStart);
    checkOutput("coef write", out, -8193);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
